if_id_stage: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection and branch flush for the 32-bit MIPS five-stage pipeline. Captures the fetched instruction and PC+4 each cycle and decodes the register fields and sign-extended immediate. Drives PC-write enable and a bubble request into the ID/EX register, which is its direct downstream consumer. Keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_stage_if.sv | 50 +++++
 rtl/if_id_stage.sv | 122 ++++++++++++
 tb/tb_if_id_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stage_if
// Brief   : Fetch/decode/hazard signal bundle for the IF/ID pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
interface if_id_stage_if #(
  parameter int CNT_W = 16
) ();
  // Fetch side and downstream hazard inputs
  logic [31:0]      PC_plus4_in;
  logic [31:0]      Instruction_in;
  logic             Freeze_in;
  logic             Branch_taken_in;
  logic             ID_EX_MemRead_in;
  logic [4:0]       ID_EX_Rt_in;

  // Registered instruction and decoded fields
  logic [31:0]      PC_plus4_out;
  logic [31:0]      Instruction_out;
  logic             Valid_out;
  logic [5:0]       Opcode_out;
  logic [4:0]       IF_ID_Rs_out;
  logic [4:0]       IF_ID_Rt_out;
  logic [4:0]       ID_Rd_out;
  logic [31:0]      sign_extend_out;

  // Pipeline control and performance counters
  logic             PC_Write_out;
  logic             Bubble_out;
  logic [CNT_W-1:0] Stall_count_out;
  logic [CNT_W-1:0] Flush_count_out;

  modport slave (
    input  PC_plus4_in, Instruction_in, Freeze_in, Branch_taken_in,
           ID_EX_MemRead_in, ID_EX_Rt_in,
    output PC_plus4_out, Instruction_out, Valid_out, Opcode_out,
           IF_ID_Rs_out, IF_ID_Rt_out, ID_Rd_out, sign_extend_out,
           PC_Write_out, Bubble_out, Stall_count_out, Flush_count_out
  );

  modport master (
    output PC_plus4_in, Instruction_in, Freeze_in, Branch_taken_in,
           ID_EX_MemRead_in, ID_EX_Rt_in,
    input  PC_plus4_out, Instruction_out, Valid_out, Opcode_out,
           IF_ID_Rs_out, IF_ID_Rt_out, ID_Rd_out, sign_extend_out,
           PC_Write_out, Bubble_out, Stall_count_out, Flush_count_out
  );
endinterface
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stage
// Brief   : MIPS IF/ID register with load-use stall, branch flush and
//           saturating stall/flush event counters.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  if_id_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_STALL  = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [31:0]      r_instr;
  logic [31:0]      r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_hazard;
  mode_t            w_mode;
  logic [31:0]      w_instr_nxt;
  logic [31:0]      w_pc4_nxt;
  logic             w_valid_nxt;
  logic [CNT_W-1:0] w_stall_cnt_nxt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;

  // Valid gating keeps NOPs and flushed slots from ever requesting a stall.
  assign w_hazard = r_valid
                  & bus.ID_EX_MemRead_in
                  & (bus.ID_EX_Rt_in != 5'd0)
                  & ((bus.ID_EX_Rt_in == r_instr[25:21]) |
                     (bus.ID_EX_Rt_in == r_instr[20:16]));

  always_comb begin
    w_mode          = MODE_RUN;
    w_instr_nxt     = r_instr;
    w_pc4_nxt       = r_pc4;
    w_valid_nxt     = r_valid;
    w_stall_cnt_nxt = r_stall_cnt;
    w_flush_cnt_nxt = r_flush_cnt;

    // A stall wins over a branch: the branch is re-resolved once operands land.
    if (bus.Freeze_in) begin
      w_mode = MODE_FREEZE;
    end else if (w_hazard) begin
      w_mode = MODE_STALL;
    end else if (bus.Branch_taken_in) begin
      w_mode = MODE_FLUSH;
    end else begin
      w_mode = MODE_RUN;
    end

    case (w_mode)
      MODE_STALL: begin
        if (r_stall_cnt != c_cnt_max) begin
          w_stall_cnt_nxt = r_stall_cnt + c_cnt_one;
        end
      end
      MODE_FLUSH: begin
        w_instr_nxt = NOP_WORD;
        w_pc4_nxt   = bus.PC_plus4_in;
        w_valid_nxt = 1'b0;
        if (r_flush_cnt != c_cnt_max) begin
          w_flush_cnt_nxt = r_flush_cnt + c_cnt_one;
        end
      end
      MODE_RUN: begin
        w_instr_nxt = bus.Instruction_in;
        w_pc4_nxt   = bus.PC_plus4_in;
        w_valid_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= NOP_WORD;
      r_pc4       <= 32'd0;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_instr     <= w_instr_nxt;
      r_pc4       <= w_pc4_nxt;
      r_valid     <= w_valid_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  assign bus.Instruction_out = r_instr;
  assign bus.PC_plus4_out    = r_pc4;
  assign bus.Valid_out       = r_valid;
  assign bus.Opcode_out      = r_instr[31:26];
  assign bus.IF_ID_Rs_out    = r_instr[25:21];
  assign bus.IF_ID_Rt_out    = r_instr[20:16];
  assign bus.ID_Rd_out       = r_instr[15:11];
  assign bus.sign_extend_out = {{16{r_instr[15]}}, r_instr[15:0]};

  assign bus.PC_Write_out    = ~bus.Freeze_in & ~w_hazard;
  assign bus.Bubble_out      = w_hazard & ~bus.Freeze_in;
  assign bus.Stall_count_out = r_stall_cnt;
  assign bus.Flush_count_out = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_if_id_stage
// Brief   : Scoreboard bench for the IF/ID register, hazard and flush logic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [15:0] stall;
    logic [15:0] flush;
  } snap_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  snap_t m;
  snap_t exp_q[$];

  if_id_stage_if #(.CNT_W(16)) bus ();

  if_id_stage #(
    .NOP_WORD (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic snap_t observe();
    snap_t s;
    s = {bus.Instruction_out, bus.PC_plus4_out, bus.Valid_out,
         bus.Stall_count_out, bus.Flush_count_out};
    return s;
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic [31:0] pc,
                        input logic frz, input logic br, input logic mr,
                        input logic [4:0] rt);
    bus.Instruction_in   = ins;
    bus.PC_plus4_in      = pc;
    bus.Freeze_in        = frz;
    bus.Branch_taken_in  = br;
    bus.ID_EX_MemRead_in = mr;
    bus.ID_EX_Rt_in      = rt;
  endtask

  // Reference model update for one rising edge; result queued for comparison.
  task automatic edge_push();
    logic hz;
    hz = m.valid & bus.ID_EX_MemRead_in & (bus.ID_EX_Rt_in != 5'd0) &
         ((bus.ID_EX_Rt_in == m.instr[25:21]) | (bus.ID_EX_Rt_in == m.instr[20:16]));
    if (!bus.Freeze_in) begin
      if (hz) begin
        if (m.stall != 16'hFFFF) m.stall = m.stall + 16'd1;
      end else if (bus.Branch_taken_in) begin
        m.instr = 32'h0;
        m.pc    = bus.PC_plus4_in;
        m.valid = 1'b0;
        if (m.flush != 16'hFFFF) m.flush = m.flush + 16'd1;
      end else begin
        m.instr = bus.Instruction_in;
        m.pc    = bus.PC_plus4_in;
        m.valid = 1'b1;
      end
    end
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t got, ex;
    rst_n = 1'b0;
    set_in(32'h8C22_0004, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 5'd0);
    m = '0;
    @(negedge clk);
    got = observe();
    n_cmp++;
    if (got !== snap_t'(0)) begin
      n_bad++; $display("FAIL reset_state got=%h exp=%h", got, snap_t'(0));
    end
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out, bus.sign_extend_out} !== {2'b10, 32'h0}) begin
      n_bad++; $display("FAIL reset_ctrl got pcw=%b bub=%b sext=%h exp 1 0 0",
                        bus.PC_Write_out, bus.Bubble_out, bus.sign_extend_out);
    end
    bus.Freeze_in = 1'b1;
    #1;
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b00) begin
      n_bad++; $display("FAIL reset_freeze got pcw=%b bub=%b exp 0 0",
                        bus.PC_Write_out, bus.Bubble_out);
    end
    bus.Freeze_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    edge_push();
    got = observe();
    ex  = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin
      n_bad++; $display("FAIL reset_first_capture got=%h exp=%h", got, ex);
    end
    n_cmp++;
    if ({bus.Opcode_out, bus.IF_ID_Rs_out, bus.IF_ID_Rt_out, bus.sign_extend_out, bus.Valid_out}
        !== {6'h23, 5'd1, 5'd2, 32'd4, 1'b1}) begin
      n_bad++; $display("FAIL reset_fields got op=%h rs=%0d rt=%0d sext=%h v=%b exp 23 1 2 4 1",
                        bus.Opcode_out, bus.IF_ID_Rs_out, bus.IF_ID_Rt_out,
                        bus.sign_extend_out, bus.Valid_out);
    end
  endtask

  task automatic test_load_use();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h0043_2020, 32'h0000_0108, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL lu_load got=%h exp=%h", got, ex); end
    @(negedge clk);
    set_in(32'h00A6_3820, 32'h0000_010C, 1'b0, 1'b0, 1'b1, 5'd2);
    #1;
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b01) begin
      n_bad++; $display("FAIL lu_ctrl got pcw=%b bub=%b exp 0 1", bus.PC_Write_out, bus.Bubble_out);
    end
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.Instruction_out !== 32'h0043_2020 || bus.Stall_count_out !== 16'd1) begin
      n_bad++; $display("FAIL lu_hold got=%h exp=%h", got, ex);
    end
    @(negedge clk);
    bus.ID_EX_MemRead_in = 1'b0;
    #1;
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b10) begin
      n_bad++; $display("FAIL lu_release got pcw=%b bub=%b exp 1 0", bus.PC_Write_out, bus.Bubble_out);
    end
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.ID_Rd_out !== 5'd7) begin
      n_bad++; $display("FAIL lu_advance got=%h rd=%0d exp=%h rd=7", got, bus.ID_Rd_out, ex);
    end
  endtask

  task automatic test_zero_exempt();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h0003_2020, 32'h0000_0110, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL zero_load got=%h exp=%h", got, ex); end
    @(negedge clk);
    set_in(32'h8C85_FFFC, 32'h0000_0114, 1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b10) begin
      n_bad++; $display("FAIL zero_ctrl got pcw=%b bub=%b exp 1 0", bus.PC_Write_out, bus.Bubble_out);
    end
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.sign_extend_out !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL zero_advance got=%h sext=%h exp=%h sext=fffffffc",
                        got, bus.sign_extend_out, ex);
    end
  endtask

  task automatic test_flush();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h2108_0001, 32'h0000_0118, 1'b0, 1'b1, 1'b0, 5'd0);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.Instruction_out !== 32'h0 || bus.Valid_out !== 1'b0 ||
        bus.Flush_count_out !== 16'd1) begin
      n_bad++; $display("FAIL flush got=%h exp=%h", got, ex);
    end
    @(negedge clk);
    set_in(32'h0128_5022, 32'h0000_011C, 1'b0, 1'b0, 1'b1, 5'd0);
    #1;
    n_cmp++;
    if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b10) begin
      n_bad++; $display("FAIL flush_nostall got pcw=%b bub=%b exp 1 0", bus.PC_Write_out, bus.Bubble_out);
    end
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL flush_refill got=%h exp=%h", got, ex); end
  endtask

  task automatic test_stall_over_branch();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h0043_2020, 32'h0000_0120, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL sob_load got=%h exp=%h", got, ex); end
    @(negedge clk);
    set_in(32'h2108_0001, 32'h0000_0124, 1'b0, 1'b1, 1'b1, 5'd3);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.Flush_count_out !== 16'd1 || bus.Stall_count_out !== 16'd2) begin
      n_bad++; $display("FAIL stall_over_branch got=%h exp=%h", got, ex);
    end
  endtask

  task automatic test_freeze();
    snap_t got, ex;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(32'hDEAD_BEEF, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 5'd3);
      #1;
      n_cmp++;
      if ({bus.PC_Write_out, bus.Bubble_out} !== 2'b00) begin
        n_bad++; $display("FAIL freeze_ctrl%0d got pcw=%b bub=%b exp 0 0", i,
                          bus.PC_Write_out, bus.Bubble_out);
      end
      edge_push();
      got = observe(); ex = exp_q.pop_front();
      n_cmp++;
      if (got !== ex) begin n_bad++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, got, ex); end
    end
    @(negedge clk);
    bus.Freeze_in = 1'b0;
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.Stall_count_out !== 16'd3) begin
      n_bad++; $display("FAIL freeze_release got=%h exp=%h", got, ex);
    end
    @(negedge clk);
    bus.ID_EX_MemRead_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    snap_t got, ex;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_in($urandom, 32'h0000_0300 + 32'(4 * i), 1'b0, 1'(i == 3), 1'b0, 5'd0);
      edge_push();
      got = observe(); ex = exp_q.pop_front();
      n_cmp++;
      if (got !== ex) begin n_bad++; $display("FAIL b2b%0d got=%h exp=%h", i, got, ex); end
    end
  endtask

  task automatic test_reset_mid_stall();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h0043_2020, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_push();
    ex = exp_q.pop_front();
    @(negedge clk);
    set_in(32'h1111_1111, 32'h0000_0404, 1'b0, 1'b1, 1'b1, 5'd2);
    #1;
    rst_n = 1'b0;
    #1;
    m = '0;
    got = observe();
    n_cmp++;
    if (got !== snap_t'(0) || bus.PC_Write_out !== 1'b1 || bus.Bubble_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_abort got=%h pcw=%b bub=%b exp=0 pcw=1 bub=0",
                        got, bus.PC_Write_out, bus.Bubble_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(32'h0043_2020, 32'h0000_0408, 1'b0, 1'b0, 1'b0, 5'd0);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL reset_recover got=%h exp=%h", got, ex); end
  endtask

  task automatic test_saturation();
    snap_t got, ex;
    @(negedge clk);
    set_in(32'h0000_0000, 32'h0000_0500, 1'b0, 1'b0, 1'b1, 5'd2);
    repeat (65535) @(posedge clk);
    #1;
    m.stall = 16'hFFFF;
    got = observe();
    n_cmp++;
    if (got !== m) begin n_bad++; $display("FAIL sat_preload got=%h exp=%h", got, m); end
    @(negedge clk);
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex || bus.Stall_count_out !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_hold got=%h exp=%h", got, ex);
    end
    @(negedge clk);
    bus.ID_EX_MemRead_in = 1'b0;
    edge_push();
    got = observe(); ex = exp_q.pop_front();
    n_cmp++;
    if (got !== ex) begin n_bad++; $display("FAIL sat_release got=%h exp=%h", got, ex); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_use();
    test_zero_exempt();
    test_flush();
    test_stall_over_branch();
    test_freeze();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
